// File: rtl/store_unit.sv
// Store unit: aligns and formats SB/SH/SW stores into byte lanes, buffers them
// in an in-order FIFO and issues them to the data-memory write port.
module store_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [2:0]        req_store_control,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic              busy
);

  localparam logic [2:0] CTRL_SB = 3'b000;
  localparam logic [2:0] CTRL_SH = 3'b001;
  localparam logic [2:0] CTRL_SW = 3'b010;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] r_addr_q  [DEPTH];
  logic [31:0]       r_wdata_q [DEPTH];
  logic [3:0]        r_wstrb_q [DEPTH];

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_misalign;
  logic [ADDR_W-1:0] r_misalign_addr;

  logic              w_misaligned;
  logic              w_accept;
  logic              w_enq;
  logic              w_deq;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic [ADDR_W-1:0] w_word_addr;

  // Unknown control codes fall through to byte-store behaviour.
  always_comb begin
    w_misaligned = 1'b0;
    w_wdata      = {4{req_data[7:0]}};
    w_wstrb      = 4'b0001 << req_addr[1:0];
    case (req_store_control)
      CTRL_SH: begin
        w_misaligned = req_addr[0];
        w_wdata      = {2{req_data[15:0]}};
        w_wstrb      = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      CTRL_SW: begin
        w_misaligned = (req_addr[1:0] != 2'b00);
        w_wdata      = req_data;
        w_wstrb      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_ready   = (r_count != DEPTH_C);
  assign w_accept    = req_valid && req_ready;
  assign w_enq       = w_accept && !w_misaligned;
  assign w_deq       = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
      else if (!w_enq && w_deq) r_count <= r_count - CW'(1);
      r_misalign <= w_accept && w_misaligned;
      if (w_accept && w_misaligned) r_misalign_addr <= req_addr;
    end
  end

  // Payload storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_q[r_wptr]  <= w_word_addr;
      r_wdata_q[r_wptr] <= w_wdata;
      r_wstrb_q[r_wptr] <= w_wstrb;
    end
  end

  assign mem_valid     = (r_count != '0);
  assign busy          = mem_valid;
  assign mem_addr      = mem_valid ? r_addr_q[r_rptr]  : '0;
  assign mem_wdata     = mem_valid ? r_wdata_q[r_rptr] : '0;
  assign mem_wstrb     = mem_valid ? r_wstrb_q[r_rptr] : '0;
  assign misalign      = r_misalign;
  assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: hand-computed vectors plus an in-order
// write monitor fed by the stimulus with expected memory writes.
module tb_store_unit;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_store_control;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        busy;

  store_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_store_control (req_store_control),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .misalign          (misalign),
    .misalign_addr     (misalign_addr),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // A write transfers at the next rising edge; sample it on the falling edge.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr",  64'(mem_addr),  64'(e.a));
        chk("wr_wdata", 64'(mem_wdata), 64'(e.d));
        chk("wr_wstrb", 64'(mem_wstrb), 64'(e.s));
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.a = a; e.d = d; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_store_control = c;
    for (int t = 0; t < 50; t++) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("req_accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w0;
    int c0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_store_control = SB;
    mem_ready = 1'b1;
    #2;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_misalign_addr", 64'(misalign_addr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic word store, one-cycle latency then drained.
    expect_wr(32'h1000, 32'hDEAD_BEEF, 4'b1111);
    send(32'h1000, 32'hDEAD_BEEF, SW);
    chk("sw_mem_valid", 64'(mem_valid), 64'd1);
    chk("sw_mem_addr", 64'(mem_addr), 64'h1000);
    chk("sw_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("sw_mem_wstrb", 64'(mem_wstrb), 64'hF);
    tick(1);
    chk("sw_drained_valid", 64'(mem_valid), 64'd0);
    chk("sw_drained_busy", 64'(busy), 64'd0);

    // Byte and half formatting.
    expect_wr(32'h2000, 32'hA5A5_A5A5, 4'b1000);
    send(32'h2003, 32'h0000_00A5, SB);
    chk("sb_mem_addr", 64'(mem_addr), 64'h2000);
    chk("sb_mem_wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
    chk("sb_mem_wstrb", 64'(mem_wstrb), 64'h8);
    expect_wr(32'h2000, 32'h1234_1234, 4'b1100);
    send(32'h2002, 32'h0000_1234, SH);
    chk("sh_hi_mem_wdata", 64'(mem_wdata), 64'h1234_1234);
    chk("sh_hi_mem_wstrb", 64'(mem_wstrb), 64'hC);
    expect_wr(32'h3000, 32'hBEEF_BEEF, 4'b0011);
    send(32'h3000, 32'hFFFF_BEEF, SH);
    chk("sh_lo_mem_wstrb", 64'(mem_wstrb), 64'h3);
    expect_wr(32'h3000, 32'h5A5A_5A5A, 4'b0010);
    send(32'h3001, 32'h1234_565A, SB);
    chk("sb_odd_mem_wstrb", 64'(mem_wstrb), 64'h2);
    chk("sb_odd_no_misalign", 64'(misalign), 64'd0);
    expect_wr(32'h3000, 32'h1111_1111, 4'b0100);
    send(32'h3002, 32'h0000_0011, 3'b111);
    chk("other_code_wstrb", 64'(mem_wstrb), 64'h4);
    chk("other_code_wdata", 64'(mem_wdata), 64'h1111_1111);
    expect_wr(32'h3004, 32'h7777_7777, 4'b0010);
    send(32'h3005, 32'h0000_0077, 3'b101);
    chk("other_code_odd_misalign", 64'(misalign), 64'd0);
    chk("other_code_odd_wstrb", 64'(mem_wstrb), 64'h2);
    tick(1);

    // Misaligned rejects, back-to-back pulses.
    send(32'h3002, 32'h0BAD_0BAD, SW);
    chk("mis_sw_pulse", 64'(misalign), 64'd1);
    chk("mis_sw_addr", 64'(misalign_addr), 64'h3002);
    chk("mis_sw_no_valid", 64'(mem_valid), 64'd0);
    send(32'h3001, 32'h0000_0BAD, SH);
    chk("mis_sh_pulse", 64'(misalign), 64'd1);
    chk("mis_sh_addr", 64'(misalign_addr), 64'h3001);
    chk("mis_sh_no_valid", 64'(mem_valid), 64'd0);
    tick(1);
    chk("mis_pulse_end", 64'(misalign), 64'd0);
    chk("mis_addr_held", 64'(misalign_addr), 64'h3001);
    chk("mis_busy", 64'(busy), 64'd0);

    // Backpressure: fill, hold third, then release in order.
    mem_ready = 1'b0;
    expect_wr(32'h4000, 32'hA000_0000, 4'hF);
    expect_wr(32'h4004, 32'hA000_0001, 4'hF);
    expect_wr(32'h4008, 32'hA000_0002, 4'hF);
    send(32'h4000, 32'hA000_0000, SW);
    send(32'h4004, 32'hA000_0001, SW);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    req_addr = 32'h4008;
    req_data = 32'hA000_0002;
    req_store_control = SW;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_mem_addr", 64'(mem_addr), 64'h4000);
      chk("stall_mem_wdata", 64'(mem_wdata), 64'hA000_0000);
      chk("stall_mem_valid", 64'(mem_valid), 64'd1);
    end
    mem_ready = 1'b1;
    send(32'h4008, 32'hA000_0002, SW);
    tick(3);
    chk("bp_drained", 64'(busy), 64'd0);

    // Sustained throughput across pointer wrap.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_wr(32'h5000 + 32'(4 * i), 32'h5000_0000 + 32'(i), 4'hF);
    send(32'h5000, 32'h5000_0000, SW);
    send(32'h5004, 32'h5000_0001, SW);
    mem_ready = 1'b1;
    c0 = cyc;
    w0 = wr_cnt;
    for (int i = 2; i < 5; i++) send(32'h5000 + 32'(4 * i), 32'h5000_0000 + 32'(i), SW);
    for (int t = 0; t < 20 && busy; t++) begin
      @(posedge clk); #1;
    end
    chk("sustain_cycles", 64'(cyc - c0), 64'd5);
    chk("sustain_writes", 64'(wr_cnt - w0), 64'd5);

    // Async reset with two stores buffered.
    mem_ready = 1'b0;
    send(32'h6000, 32'h6666_0000, SW);
    send(32'h6004, 32'h6666_0001, SW);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", 64'(mem_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    mem_ready = 1'b1;
    w0 = wr_cnt;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick(4);
    chk("arst_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("arst_idle_valid", 64'(mem_valid), 64'd0);

    // Async reset while a misalign pulse is high.
    mem_ready = 1'b0;
    send(32'h7000, 32'h7777_0000, SW);
    send(32'h7001, 32'h7777_0001, SW);
    chk("arst2_pre_misalign", 64'(misalign), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst2_misalign", 64'(misalign), 64'd0);
    chk("arst2_misalign_addr", 64'(misalign_addr), 64'd0);
    chk("arst2_busy", 64'(busy), 64'd0);
    mem_ready = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(3);
    chk("arst2_no_write", 64'(wr_cnt - w0), 64'd0);

    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Memory-side consumer of decoded store instructions. Takes the effective address, the rs2 value and the 3-bit store_control (SB/SH/SW) produced by store decode, checks alignment and formats the data into byte lanes with write strobes. Buffers accepted stores in an in-order FIFO and issues them to the data-memory write port over a valid/ready handshake. Sits between the execute stage and data memory.

Parameters:
DEPTH, 2, store buffer entries; power of two, >= 2
ADDR_W, 32, address width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request this cycle
req_addr  input  ADDR_W  effective byte address (rs1 + imm, computed upstream)
req_data  input  32  rs2 value, right-justified
req_store_control  input  3  `SB / `SH / `SW, per the shared define file
mem_valid  output  1  head store presented to memory
mem_ready  input  1  memory accepts head store
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_wstrb  output  4  byte write strobes, bit i = byte lane i
misalign  output  1  one-cycle pulse: misaligned store rejected
misalign_addr  output  ADDR_W  byte address of last misaligned store
busy  output  1  buffer non-empty

Behaviour:
- Reset (async on rst_n low, released synchronously in effect): count, read/write pointers = 0; mem_valid=0, misalign=0, misalign_addr=0, busy=0; mem_addr/mem_wdata/mem_wstrb=0. Reset mid-operation discards all buffered stores; no memory write is issued for them.
- req_ready = (count != DEPTH); combinational from count only, not from req_valid.
- Accept = req_valid && req_ready, sampled at the rising edge.
- Alignment: SH misaligned if addr[0]=1; SW misaligned if addr[1:0]!=0; SB never misaligned. Any control code other than `SH/`SW is treated as `SB.
- Misaligned accepted request: not enqueued; next cycle misalign=1 for exactly one cycle, misalign_addr = req_addr (held until next misaligned store). Back-to-back misaligned requests give misalign high on consecutive cycles.
- Aligned accepted request is formatted and written to the FIFO tail:
  SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << addr[1:0]
  SH: wdata = {2{data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011
  SW: wdata = data, wstrb = 4'b1111
  stored address = {addr[ADDR_W-1:2],2'b00}.
- Latency: an aligned store accepted at edge N appears on mem_valid after edge N (no combinational passthrough from req_* to mem_*).
- mem_valid = (count != 0); mem_addr/mem_wdata/mem_wstrb = head entry; driven 0 when empty.
- Dequeue = mem_valid && mem_ready. While mem_valid && !mem_ready, mem_* outputs stay stable.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. When full, no enqueue even if a dequeue happens the same cycle (req_ready already 0).
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
- Strict in-order issue; stores never merged or reordered.
- busy = (count != 0).

Test Plan:
- Reset then SW addr 0x1000 data 0xDEADBEEF, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xDEADBEEF, mem_wstrb=4'b1111; cleared the following cycle, busy=0.
- SB addr 0x2003 data 0x000000A5 -> mem_addr=0x2000, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b1000; SH addr 0x2002 data 0x1234 -> mem_wdata=0x12341234, mem_wstrb=4'b1100.
- SW addr 0x3002 -> no mem_valid, misalign pulses 1 cycle, misalign_addr=0x3002; SH addr 0x3001 next cycle -> second consecutive pulse, misalign_addr=0x3001.
- mem_ready=0, issue 3 aligned SWs (DEPTH=2) -> req_ready=0 after 2 accepted, third held; mem_* stable; raise mem_ready -> three writes issue in order.
- Full buffer with mem_ready=1 and req_valid=1 continuous -> sustained one write per cycle after fill, ordering preserved across pointer wrap (at least 2*DEPTH+1 stores).
- Two stores buffered, assert rst_n=0 asynchronously mid-cycle -> mem_valid, busy, misalign drop to 0 immediately; no write issued after reset release.
